// File: rtl/u_rca_mw_seq.sv
// Multi-cycle wide unsigned adder: one WORD_W-bit ripple-carry slice is reused
// over NWORDS cycles (LSW first), with the inter-word carry held in a register.

module u_rca_mw_seq_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   logic w_p;

   assign w_p = i_a ^ i_b;
   assign o_s = w_p ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module u_rca_mw_seq #(
   parameter int WORD_W = 24,
   parameter int NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NWORDS*WORD_W-1:0] a,
   input  logic [NWORDS*WORD_W-1:0] b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NWORDS*WORD_W:0]   sum,
   output logic                     busy
);
   localparam int OP_W  = NWORDS * WORD_W;
   localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_carry;
   logic [OP_W-1:0]   r_a;
   logic [OP_W-1:0]   r_b;
   logic [OP_W:0]     r_sum;
   logic              r_out_valid;

   logic [WORD_W-1:0] w_a_word;
   logic [WORD_W-1:0] w_b_word;
   logic [WORD_W-1:0] w_s;
   logic [WORD_W:0]   w_c;

   // Operand word selected by the word counter feeds the shared slice.
   always_comb begin
      w_a_word = '0;
      w_b_word = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (r_cnt == CNT_W'(k)) begin
            w_a_word = r_a[k*WORD_W +: WORD_W];
            w_b_word = r_b[k*WORD_W +: WORD_W];
         end
      end
   end

   assign w_c[0] = r_carry;

   generate
      for (genvar gi = 0; gi < WORD_W; gi++) begin : g_slice
         u_rca_mw_seq_fa u_fa (
            .i_a (w_a_word[gi]),
            .i_b (w_b_word[gi]),
            .i_c (w_c[gi]),
            .o_s (w_s[gi]),
            .o_c (w_c[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
                  r_sum   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               for (int k = 0; k < NWORDS; k++) begin
                  if (r_cnt == CNT_W'(k)) begin
                     r_sum[k*WORD_W +: WORD_W] <= w_s;
                  end
               end
               r_carry <= w_c[WORD_W];
               // Last word: carry-out becomes the sum MSB and the counter parks at 0.
               if (r_cnt == LAST_CNT) begin
                  r_sum[OP_W] <= w_c[WORD_W];
                  r_cnt       <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
endmodule
